// File: rtl/uart_bus_arbiter.sv
// Shares the UART device port between master 0 (CPU) and master 1 (debug/loader): round-robin on contention,
// one transaction in flight, one device select cycle per transaction. Optional ack timeout: UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        m0_sel_i,
  input  logic        m0_wr_en_i,
  input  logic [11:0] m0_address_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_sel_i,
  input  logic        m1_wr_en_i,
  input  logic [11:0] m1_address_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        s_sel_o,
  output logic        s_wr_en_o,
  output logic [11:0] s_address_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic        busy_o,
  output logic        grant_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q;
  logic        s_sel_q;
  logic        s_wr_en_q;
  logic [11:0] s_address_q;
  logic [31:0] s_data_q;
  logic        m0_ack_q;
  logic        m1_ack_q;
  logic [31:0] m0_data_q;
  logic [31:0] m1_data_q;
  logic        busy_q;
  logic        grant_q;

  logic        req_any;
  logic        grant_d;
  logic        done_d;
  logic [31:0] resp_data_d;
  logic        timeout_d;

  // On contention the master that was not granted last time wins.
  always_comb begin
    req_any = m0_sel_i | m1_sel_i;
    if (m0_sel_i && m1_sel_i) begin
      grant_d = ~grant_q;
    end else begin
      grant_d = m1_sel_i;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W1 = CNT_W + 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W:0]   wait_cnt_d;
  logic             err_q;

  assign wait_cnt_d = {1'b0, wait_cnt_q} + CNT_W1'(1);
  assign timeout_d  = (state_q == WAIT) && !s_ack_i && (wait_cnt_d == CNT_W1'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= timeout_d;
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT && !s_ack_i) begin
        wait_cnt_q <= wait_cnt_d[CNT_W-1:0];
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_d          = 1'b0;
  assign err_o              = 1'b0;
`endif

  // An ack arriving in the select cycle itself completes the transaction as well.
  always_comb begin
    done_d      = 1'b0;
    resp_data_d = s_data_i;
    if ((state_q == ISSUE || state_q == WAIT) && s_ack_i) begin
      done_d = 1'b1;
    end else if (timeout_d) begin
      done_d      = 1'b1;
      resp_data_d = TIMEOUT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      s_sel_q     <= 1'b0;
      s_wr_en_q   <= 1'b0;
      s_address_q <= '0;
      s_data_q    <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_data_q   <= '0;
      m1_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b1;
    end else begin
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            grant_q     <= grant_d;
            s_sel_q     <= 1'b1;
            s_wr_en_q   <= grant_d ? m1_wr_en_i   : m0_wr_en_i;
            s_address_q <= grant_d ? m1_address_i : m0_address_i;
            s_data_q    <= grant_d ? m1_data_i    : m0_data_i;
          end
        end
        ISSUE, WAIT: begin
          s_sel_q <= 1'b0;
          if (done_d) begin
            state_q   <= RESP;
            m0_ack_q  <= ~grant_q;
            m1_ack_q  <= grant_q;
            m0_data_q <= grant_q ? 32'h0 : resp_data_d;
            m1_data_q <= grant_q ? resp_data_d : 32'h0;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_sel_o     = s_sel_q;
  assign s_wr_en_o   = s_wr_en_q;
  assign s_address_o = s_address_q;
  assign s_data_o    = s_data_q;
  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign m0_data_o   = m0_data_q;
  assign m1_data_o   = m1_data_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: transaction-level timestamp model checked every cycle, plus directed literal checks.
module tb_uart_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m0_sel_i, m0_wr_en_i, m1_sel_i, m1_wr_en_i;
  logic [11:0] m0_address_i, m1_address_i;
  logic [31:0] m0_data_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o;
  logic        s_sel_o, s_wr_en_o;
  logic [11:0] s_address_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;
  logic        busy_o, grant_o, err_o;

  uart_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_sel_i(m0_sel_i), .m0_wr_en_i(m0_wr_en_i), .m0_address_i(m0_address_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_sel_i(m1_sel_i), .m1_wr_en_i(m1_wr_en_i), .m1_address_i(m1_address_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .s_sel_o(s_sel_o), .s_wr_en_o(s_wr_en_o), .s_address_o(s_address_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .busy_o(busy_o), .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dev_rd(input logic [11:0] a);
    if (a == 12'h004) return 32'h0000_0003;
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  // Device model: acks dev_delay cycles after seeing the select (0 = in the select cycle).
  int          dev_delay = 1;
  bit          dev_mute  = 1'b0;
  int          stray_cyc = -1;
  int          dev_cnt;
  bit          dev_pend  = 1'b0;
  bit          dev_wr;
  logic [11:0] dev_addr;

  initial forever begin
    @(negedge clk);
    s_ack_i  = 1'b0;
    s_data_i = 32'h0;
    if (reset_i) begin
      dev_pend = 1'b0;
    end else begin
      if (s_sel_o && !dev_mute) begin
        dev_pend = 1'b1;
        dev_cnt  = dev_delay;
        dev_wr   = s_wr_en_o;
        dev_addr = s_address_o;
      end
      if (dev_pend) begin
        if (dev_cnt == 0) begin
          s_ack_i  = 1'b1;
          s_data_i = dev_wr ? 32'h0 : dev_rd(dev_addr);
          dev_pend = 1'b0;
        end else begin
          dev_cnt--;
        end
      end else if (cyc == stray_cyc) begin
        s_ack_i  = 1'b1;
        s_data_i = 32'h5A5A_5A5A;
      end
    end
  end

  // Model: a transaction is stamped with its select cycle and its completion cycle.
  bit          model_ok = 1'b0;
  bit          mdl_active = 1'b0;
  int          t_issue, t_resp;
  bit          mdl_mst, mdl_to;
  logic [31:0] mdl_rdata;
  logic        e_wr, e_grant;
  logic [11:0] e_addr;
  logic [31:0] e_wdata;
  int          c_now;

  initial forever begin
    @(posedge clk);
    c_now = cyc;
    if (reset_i) begin
      mdl_active = 1'b0; e_wr = 1'b0; e_addr = 12'h0; e_wdata = 32'h0; e_grant = 1'b1;
      t_resp = -1; mdl_to = 1'b0; model_ok = 1'b1;
    end else if (!mdl_active) begin
      if (m0_sel_i || m1_sel_i) begin
        mdl_mst    = (m0_sel_i && m1_sel_i) ? !e_grant : m1_sel_i;
        e_grant    = mdl_mst;
        e_wr       = mdl_mst ? m1_wr_en_i : m0_wr_en_i;
        e_addr     = mdl_mst ? m1_address_i : m0_address_i;
        e_wdata    = mdl_mst ? m1_data_i : m0_data_i;
        mdl_active = 1'b1;
        t_issue    = c_now + 1;
        t_resp     = -1;
        mdl_to     = 1'b0;
      end
    end else if (t_resp < 0) begin
      if (c_now >= t_issue && s_ack_i) begin
        t_resp    = c_now + 1;
        mdl_rdata = s_data_i;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (c_now - t_issue == TO) begin
        t_resp    = c_now + 1;
        mdl_rdata = 32'hDEAD_BEEF;
        mdl_to    = 1'b1;
      end
`endif
    end else if (c_now == t_resp) begin
      mdl_active = 1'b0;
    end
    cyc = c_now + 1;
  end

  typedef struct {int c; bit g; bit wr; logic [11:0] a; logic [31:0] d;} sel_t;
  typedef struct {int c; int m; logic [31:0] d; logic [31:0] od; bit err; bit g;} ack_t;
  sel_t sel_log[$];
  ack_t ack_log[$];

  // Per-cycle compare against the model, plus event logging for the directed checks.
  bit          x_ack;
  logic [31:0] x_d;
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      x_ack = mdl_active && (cyc == t_resp);
      x_d   = x_ack ? mdl_rdata : 32'h0;
      chk("s_sel",   32'(s_sel_o),     32'(mdl_active && cyc == t_issue));
      chk("s_wr_en", 32'(s_wr_en_o),   32'(e_wr));
      chk("s_addr",  32'(s_address_o), 32'(e_addr));
      chk("s_data",  s_data_o,         e_wdata);
      chk("busy",    32'(busy_o),      32'(mdl_active));
      chk("grant",   32'(grant_o),     32'(e_grant));
      chk("m0_ack",  32'(m0_ack_o),    32'(x_ack && !mdl_mst));
      chk("m1_ack",  32'(m1_ack_o),    32'(x_ack && mdl_mst));
      chk("m0_data", m0_data_o,        mdl_mst ? 32'h0 : x_d);
      chk("m1_data", m1_data_o,        mdl_mst ? x_d : 32'h0);
      chk("err",     32'(err_o),       32'(x_ack && mdl_to));
    end
    if (s_sel_o)  sel_log.push_back('{cyc, grant_o, s_wr_en_o, s_address_o, s_data_o});
    if (m0_ack_o) ack_log.push_back('{cyc, 0, m0_data_o, m1_data_o, err_o, grant_o});
    if (m1_ack_o) ack_log.push_back('{cyc, 1, m1_data_o, m0_data_o, err_o, grant_o});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int m, input bit sel, input bit wr, input logic [11:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_sel_i = sel; m0_wr_en_i = wr; m0_address_i = a; m0_data_i = d;
    end else begin
      m1_sel_i = sel; m1_wr_en_i = wr; m1_address_i = a; m1_data_i = d;
    end
  endtask

  // Issues n back-to-back requests, holding sel through each ack.
  task automatic master_seq(input int m, input int n, input bit wr, input logic [11:0] a0, input logic [31:0] d0);
    int budget;
    bit seen;
    for (int k = 0; k < n; k++) begin
      drive(m, 1'b1, wr, a0 + 12'(4 * k), d0 + 32'(k));
      budget = 0;
      seen   = 1'b0;
      while (!seen && budget < 60) begin
        @(negedge clk);
        budget++;
        seen = (m == 0) ? m0_ack_o : m1_ack_o;
      end
      chk($sformatf("ack_seen_m%0d", m), 32'(seen), 32'h1);
    end
    drive(m, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    tick(1);
  endtask

  int t0, sb, ab;

  initial begin
    reset_i = 1'b1;
    drive(0, 1'b0, 1'b0, 12'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 12'h0, 32'h0);
    s_ack_i = 1'b0; s_data_i = 32'h0;
    tick(3);
    reset_i = 1'b0;
    tick(1);
    chk("rst_grant", 32'(grant_o), 32'h1);
    chk("rst_busy",  32'(busy_o),  32'h0);
    chk("rst_sel",   32'(s_sel_o), 32'h0);
    chk("rst_acks",  32'({m0_ack_o, m1_ack_o}), 32'h0);

    // m0 write 0x41 to 0x000
    sb = sel_log.size(); ab = ack_log.size();
    dev_delay = 1; t0 = cyc;
    master_seq(0, 1, 1'b1, 12'h000, 32'h0000_0041);
    tick(2);
    chk("t1_nsel", sel_log.size() - sb, 1);
    chk("t1_nack", ack_log.size() - ab, 1);
    if (sel_log.size() > sb) begin
      chk("t1_sel_cyc", sel_log[sb].c - t0, 1);
      chk("t1_wr",      32'(sel_log[sb].wr), 1);
      chk("t1_addr",    32'(sel_log[sb].a), 32'h0);
      chk("t1_wdata",   sel_log[sb].d, 32'h41);
    end
    if (ack_log.size() > ab) begin
      chk("t1_ack_lat", ack_log[ab].c - t0, 3);
      chk("t1_ack_mst", ack_log[ab].m, 0);
    end

    // m1 read of 0x004, device acks in the select cycle
    sb = sel_log.size(); ab = ack_log.size();
    dev_delay = 0; t0 = cyc;
    master_seq(1, 1, 1'b0, 12'h004, 32'h0);
    tick(2);
    chk("t2_nack", ack_log.size() - ab, 1);
    if (ack_log.size() > ab) begin
      chk("t2_mst",     ack_log[ab].m, 1);
      chk("t2_rdata",   ack_log[ab].d, 32'h3);
      chk("t2_m0_data", ack_log[ab].od, 32'h0);
      chk("t2_grant",   32'(ack_log[ab].g), 1);
      chk("t2_ack_lat", ack_log[ab].c - t0, 2);
    end

    // stray device ack while idle
    ab = ack_log.size();
    stray_cyc = cyc + 1;
    tick(4);
    chk("stray_nack", ack_log.size() - ab, 0);
    chk("stray_busy", 32'(busy_o), 0);

    // reset while waiting for the device, then a clean re-request
    ab = ack_log.size();
    dev_mute = 1'b1; dev_delay = 1; t0 = cyc;
    drive(0, 1'b1, 1'b0, 12'h010, 32'h0);
    tick(2);
    chk("t5_busy_wait", 32'(busy_o), 1);
    reset_i = 1'b1;
    drive(0, 1'b0, 1'b0, 12'h0, 32'h0);
    tick(1);
    reset_i = 1'b0;
    chk("t5_busy",  32'(busy_o), 0);
    chk("t5_grant", 32'(grant_o), 1);
    chk("t5_addr",  32'(s_address_o), 0);
    chk("t5_ack",   32'(m0_ack_o), 0);
    tick(3);
    chk("t5_no_ack", ack_log.size() - ab, 0);
    dev_mute = 1'b0; t0 = cyc;
    master_seq(0, 1, 1'b0, 12'h008, 32'h0);
    tick(2);
    chk("t5_nack", ack_log.size() - ab, 1);
    if (ack_log.size() > ab) begin
      chk("t5_rdata",   ack_log[ab].d, 32'hA500_0008);
      chk("t5_ack_lat", ack_log[ab].c - t0, 3);
    end

    // simultaneous requests right after reset: m0 first
    do_reset();
    sb = sel_log.size();
    dev_delay = 2;
    fork
      master_seq(0, 1, 1'b1, 12'h020, 32'h100);
      master_seq(1, 1, 1'b1, 12'h040, 32'h200);
    join
    tick(2);
    chk("t3_nsel", sel_log.size() - sb, 2);
    if (sel_log.size() > sb + 1) begin
      chk("t3_g0", 32'(sel_log[sb].g), 0);
      chk("t3_g1", 32'(sel_log[sb + 1].g), 1);
      chk("t3_a0", 32'(sel_log[sb].a), 32'h020);
      chk("t3_a1", 32'(sel_log[sb + 1].a), 32'h040);
    end

    // sustained contention: strict alternation
    sb = sel_log.size(); ab = ack_log.size();
    dev_delay = 1;
    fork
      master_seq(0, 3, 1'b0, 12'h100, 32'h0);
      master_seq(1, 3, 1'b0, 12'h200, 32'h0);
    join
    tick(2);
    chk("t4_nsel", sel_log.size() - sb, 6);
    chk("t4_nack", ack_log.size() - ab, 6);
    for (int i = 0; i < 6; i++) begin
      if (sel_log.size() > sb + i) chk($sformatf("t4_grant%0d", i), 32'(sel_log[sb + i].g), i % 2);
      if (ack_log.size() > ab + i) chk($sformatf("t4_ackm%0d", i), ack_log[ab + i].m, i % 2);
    end

    // device never acks
    ab = ack_log.size();
    dev_mute = 1'b1; t0 = cyc;
`ifdef UART_ARB_TIMEOUT_EN
    master_seq(0, 1, 1'b0, 12'h0FC, 32'h0);
    tick(2);
    chk("t6_nack", ack_log.size() - ab, 1);
    if (ack_log.size() > ab) begin
      chk("t6_data", ack_log[ab].d, 32'hDEAD_BEEF);
      chk("t6_err",  32'(ack_log[ab].err), 1);
      chk("t6_lat",  ack_log[ab].c - t0, 2 + TO);
    end
`else
    drive(0, 1'b1, 1'b0, 12'h0FC, 32'h0);
    tick(20);
    chk("t6_busy", 32'(busy_o), 1);
    chk("t6_nack", ack_log.size() - ab, 0);
    drive(0, 1'b0, 1'b0, 12'h0, 32'h0);
    do_reset();
`endif
    dev_mute = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
